ifmap_stream_writer: RTL and testbench

// Producer end of the tagged IFMap stream consumed by Processing_element via circular_buffer.

---
 rtl/ifmap_stream_pkg.sv | 33 +++
 rtl/ifmap_stream_writer_if.sv | 30 +++
 rtl/ifmap_stream_writer_skid.sv | 52 +++++
 rtl/ifmap_stream_writer.sv | 132 +++++++++++++
 tb/tb_ifmap_stream_writer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifmap_stream_pkg.sv
// rtl/ifmap_stream_pkg.sv - shared constants, flag encodings and FSM states for the IFMap stream writer
package ifmap_stream_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned SOR_BIT        = DATA_WIDTH_DEF + 1;
  localparam int unsigned EOR_BIT        = DATA_WIDTH_DEF;

  typedef logic [1:0] flag_t;

  localparam flag_t FLAG_NONE   = 2'b00;
  localparam flag_t FLAG_SOR    = 2'b10;
  localparam flag_t FLAG_EOR    = 2'b01;
  localparam flag_t FLAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic flag_t make_flags(input logic is_sor, input logic is_eor);
    flag_t f;
    case ({is_sor, is_eor})
      2'b11:   f = FLAG_SINGLE;
      2'b10:   f = FLAG_SOR;
      2'b01:   f = FLAG_EOR;
      default: f = FLAG_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ifmap_stream_writer_if.sv
// rtl/ifmap_stream_writer_if.sv - control, scratch-read and circular-buffer signals of the stream writer
interface ifmap_stream_writer_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 6,
  parameter int ROW_CNT_WIDTH = 6
);
  logic                     start;
  logic [ADDR_WIDTH-1:0]    base_addr;
  logic [ROW_LEN_WIDTH-1:0] row_len;
  logic [ROW_CNT_WIDTH-1:0] num_rows;
  logic                     mem_ren;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     ready_buf;
  logic                     wen_buf;
  logic [DATA_WIDTH+1:0]    dout;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, base_addr, row_len, num_rows, mem_rdata, ready_buf,
    output mem_ren, mem_addr, wen_buf, dout, busy, done
  );

  modport slave (
    output start, base_addr, row_len, num_rows, mem_rdata, ready_buf,
    input  mem_ren, mem_addr, wen_buf, dout, busy, done
  );
endinterface

// File: rtl/ifmap_stream_writer_skid.sv
// rtl/ifmap_stream_writer_skid.sv - 2-entry skid FIFO holding tagged words between scratch read and buffer write
module ifmap_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // a push into a full FIFO is only taken when the head leaves in the same cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ifmap_stream_writer.sv
// rtl/ifmap_stream_writer.sv - reads a row-major IFMap tile and streams SOR/EOR-tagged words into the circular buffer
module ifmap_stream_writer
  import ifmap_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 6,
  parameter int ROW_CNT_WIDTH = 6
) (
  input logic                   i_clk,
  input logic                   i_rst,
  ifmap_stream_writer_if.master bus
);
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [ROW_LEN_WIDTH-1:0] r_row_len;
  logic [ROW_LEN_WIDTH-1:0] r_col;
  logic [ROW_CNT_WIDTH-1:0] r_num_rows;
  logic [ROW_CNT_WIDTH-1:0] r_row;
  logic                     r_inflight;
  flag_t                    r_flight_flags;

  logic                     w_ren;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_pop;
  logic                     w_credit;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_drained;
  logic                     w_zero_tile;
  logic                     w_empty;
  logic                     w_full;
  logic [1:0]               w_count;
  logic [DATA_WIDTH+1:0]    w_head;
  logic [DATA_WIDTH+1:0]    w_push_word;

  ifmap_skid_fifo #(.WIDTH(DATA_WIDTH + 2)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (w_push_word),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push_word = {r_flight_flags, bus.mem_rdata};
  assign w_pop       = ~w_empty & bus.ready_buf;
  // occupancy after this cycle's pop plus the read already in flight must leave a free slot
  assign w_credit    = (({1'b0, w_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
  assign w_last_col  = (r_col == r_row_len - ROW_LEN_WIDTH'(1));
  assign w_last_row  = (r_row == r_num_rows - ROW_CNT_WIDTH'(1));
  assign w_drained   = ~r_inflight & (w_count == {1'b0, w_pop});
  assign w_zero_tile = (bus.row_len == '0) | (bus.num_rows == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = w_zero_tile ? ST_DONE : ST_FETCH;
      ST_FETCH: if (w_ren && w_last_col && w_last_row) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drained) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ren  = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ren  = w_credit;
        w_busy = 1'b1;
      end
      ST_DRAIN: w_busy = 1'b1;
      ST_DONE:  w_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr         <= '0;
      r_row_len      <= '0;
      r_num_rows     <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_inflight     <= 1'b0;
      r_flight_flags <= FLAG_NONE;
    end else begin
      r_inflight <= w_ren;
      if (w_ren) begin
        r_flight_flags <= make_flags(r_col == '0, w_last_col);
      end
      if (r_state == ST_IDLE && bus.start) begin
        r_addr     <= bus.base_addr;
        r_row_len  <= bus.row_len;
        r_num_rows <= bus.num_rows;
        r_col      <= '0;
        r_row      <= '0;
      end else if (w_ren) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ROW_CNT_WIDTH'(1);
        end else begin
          r_col <= r_col + ROW_LEN_WIDTH'(1);
        end
      end
    end
  end

  assign bus.mem_ren  = w_ren;
  assign bus.mem_addr = r_addr;
  assign bus.wen_buf  = w_pop;
  assign bus.dout     = w_head;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
endmodule

// File: tb/tb_ifmap_stream_writer.sv
// tb/tb_ifmap_stream_writer.sv - self-checking bench for ifmap_stream_writer
`timescale 1ns/1ps
module tb_ifmap_stream_writer;
  import ifmap_stream_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int RLW = 6;
  localparam int RCW = 6;
  localparam int OW  = AW + DW + 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifmap_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN_WIDTH(RLW), .ROW_CNT_WIDTH(RCW)) bus ();

  ifmap_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN_WIDTH(RLW), .ROW_CNT_WIDTH(RCW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

  int n_tests;
  int n_fail;

  logic [DW+1:0] got_q [$];
  int            got_cyc [$];
  logic [AW-1:0] addr_q [$];
  int            ren_cyc [$];
  int            done_cyc_q [$];
  logic [DW+1:0] exp_q [$];
  bit            done_seen;

  logic [DW+1:0] obs_dout [512];
  logic [AW-1:0] obs_addr [512];
  logic          obs_wen [512];
  logic          obs_ren [512];
  logic          obs_busy [512];
  logic          obs_done [512];

  // Reference: element k of the tile is mem[base+k mod 256], tagged by its column k mod row_len.
  task automatic build_expected(input int base, input int rl, input int nr);
    logic [DW+1:0] w;
    exp_q.delete();
    for (int k = 0; k < rl * nr; k++) begin
      w = '0;
      w[DW-1:0] = mem[(base + k) % 256];
      w[SOR_BIT] = ((k % rl) == 0);
      w[EOR_BIT] = ((k % rl) == rl - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic run_tile(input logic [AW-1:0] base, input int rl, input int nr, input int mode, input int budget);
    got_q.delete(); got_cyc.delete(); addr_q.delete(); ren_cyc.delete(); done_cyc_q.delete();
    done_seen = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.row_len = RLW'(rl); bus.num_rows = RCW'(nr);
    for (int rel = 0; rel < budget; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      case (mode)
        1: bus.ready_buf = !(rel >= 4 && rel <= 7);
        2: bus.ready_buf = ($urandom_range(0, 3) != 0);
        3: begin bus.ready_buf = 1'b1; rst = (rel == 6); end
        4: begin
          bus.ready_buf = 1'b1;
          if (rel == 2) begin
            bus.start = 1'b1; bus.base_addr = ~base; bus.row_len = RLW'(rl + 2);
          end
        end
        default: bus.ready_buf = 1'b1;
      endcase
      @(negedge clk);
      obs_dout[rel] = bus.dout; obs_addr[rel] = bus.mem_addr; obs_wen[rel] = bus.wen_buf;
      obs_ren[rel] = bus.mem_ren; obs_busy[rel] = bus.busy; obs_done[rel] = bus.done;
      if (bus.wen_buf) begin got_q.push_back(bus.dout); got_cyc.push_back(rel); end
      if (bus.mem_ren) begin addr_q.push_back(bus.mem_addr); ren_cyc.push_back(rel); end
      if (bus.done) begin done_cyc_q.push_back(rel); done_seen = 1'b1; break; end
      if (mode == 3 && rel == 7) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = {bus.mem_ren, bus.mem_addr, bus.wen_buf, bus.dout, bus.busy, bus.done};
    n_tests++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", v); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    v = {bus.mem_ren, bus.mem_addr, bus.wen_buf, bus.dout, bus.busy, bus.done};
    n_tests++;
    if (v !== '0) begin n_fail++; $display("FAIL idle_after_reset got %h exp 0", v); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 6; k++) mem[8'h10 + k] = DW'(k + 1);
    build_expected(8'h10, 3, 2);
    run_tile(8'h10, 3, 2, 0, 100);
    n_tests++;
    if (!done_seen) begin n_fail++; $display("FAIL basic_timeout got no done exp done"); end
    n_tests++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL basic_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      n_tests++;
      if (got_cyc[i] != 3 + i) begin n_fail++; $display("FAIL basic_cycle%0d got %0d exp %0d", i, got_cyc[i], 3 + i); end
    end
    n_tests++;
    if (ren_cyc.size() != 6 || ren_cyc[0] != 1) begin
      n_fail++; $display("FAIL basic_reads got %0d reads exp 6 starting cycle 1", ren_cyc.size());
    end
    n_tests++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 9) begin
      n_fail++; $display("FAIL basic_done_cycle got %0d exp 9", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1);
    end
    n_tests++;
    if (obs_busy[1] !== 1'b1 || obs_busy[9] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy got %b/%b exp 1/0", obs_busy[1], obs_busy[9]);
    end
  endtask

  task automatic test_backpressure();
    int stall_reads;
    for (int k = 0; k < 6; k++) mem[8'h10 + k] = DW'(k + 1);
    build_expected(8'h10, 3, 2);
    run_tile(8'h10, 3, 2, 1, 100);
    n_tests++;
    if (!done_seen) begin n_fail++; $display("FAIL bp_timeout got no done exp done"); end
    for (int r = 4; r <= 7; r++) begin
      n_tests++;
      if (obs_wen[r] !== 1'b0 || obs_dout[r] !== exp_q[1]) begin
        n_fail++; $display("FAIL bp_hold_c%0d got wen=%b dout=%h exp wen=0 dout=%h", r, obs_wen[r], obs_dout[r], exp_q[1]);
      end
    end
    stall_reads = 0;
    foreach (ren_cyc[i]) if (ren_cyc[i] >= 4 && ren_cyc[i] <= 7) stall_reads++;
    n_tests++;
    if (stall_reads > 2 || ren_cyc.size() != 6) begin
      n_fail++; $display("FAIL bp_reads got %0d stall/%0d total exp <=2/6", stall_reads, ren_cyc.size());
    end
    n_tests++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if (got_cyc.size() < 2 || got_cyc[1] != 8) begin
      n_fail++; $display("FAIL bp_resume got %0d exp 8", got_cyc.size() > 1 ? got_cyc[1] : -1);
    end
  endtask

  task automatic test_single_col();
    logic [AW-1:0] base;
    base = AW'($urandom);
    for (int k = 0; k < 3; k++) mem[(int'(base) + k) % 256] = DW'($urandom);
    build_expected(int'(base), 1, 3);
    run_tile(base, 1, 3, 0, 100);
    n_tests++;
    if (!done_seen || got_q.size() != 3) begin
      n_fail++; $display("FAIL single_count got %0d done=%b exp 3 done=1", got_q.size(), done_seen);
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i] || got_q[i][DW+1:DW] !== FLAG_SINGLE) begin
        n_fail++; $display("FAIL single_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero();
    int rl_tab [2] = '{0, 3};
    int nr_tab [2] = '{2, 0};
    for (int t = 0; t < 2; t++) begin
      run_tile(AW'($urandom), rl_tab[t], nr_tab[t], 0, 20);
      n_tests++;
      if (!done_seen || done_cyc_q[0] != 1) begin
        n_fail++; $display("FAIL zero%0d_done got seen=%b exp done in cycle 1", t, done_seen);
      end
      n_tests++;
      if (ren_cyc.size() != 0 || got_q.size() != 0) begin
        n_fail++; $display("FAIL zero%0d_traffic got %0d reads %0d writes exp 0 0", t, ren_cyc.size(), got_q.size());
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    foreach (exp_addr[i]) mem[exp_addr[i]] = DW'($urandom);
    build_expected(8'hFE, 4, 1);
    run_tile(8'hFE, 4, 1, 0, 100);
    n_tests++;
    if (!done_seen || addr_q.size() != 4 || got_q.size() != 4) begin
      n_fail++; $display("FAIL wrap_count got %0d reads %0d writes exp 4 4", addr_q.size(), got_q.size());
    end
    for (int i = 0; i < 4 && i < addr_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (addr_q[i] !== exp_addr[i] || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_%0d got addr %h word %h exp addr %h word %h", i, addr_q[i], got_q[i], exp_addr[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 6; k++) mem[8'h40 + k] = DW'($urandom);
    build_expected(8'h40, 3, 2);
    run_tile(8'h40, 3, 2, 4, 100);
    n_tests++;
    if (!done_seen || got_q.size() != 6) begin
      n_fail++; $display("FAIL restart_ignored got %0d words exp 6", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] v;
    for (int k = 0; k < 6; k++) mem[8'h10 + k] = DW'(k + 1);
    build_expected(8'h10, 3, 2);
    run_tile(8'h10, 3, 2, 3, 100);
    n_tests++;
    if (got_q.size() != 4) begin n_fail++; $display("FAIL midrst_pre got %0d words exp 4", got_q.size()); end
    v = {obs_ren[7], obs_addr[7], obs_wen[7], obs_dout[7], obs_busy[7], obs_done[7]};
    n_tests++;
    if (v !== '0) begin n_fail++; $display("FAIL midrst_outputs got %h exp 0", v); end
    run_tile(8'h10, 3, 2, 0, 100);
    n_tests++;
    if (!done_seen || got_q.size() != 6 || got_cyc[0] != 3) begin
      n_fail++; $display("FAIL midrst_restart got %0d words exp 6 from cycle 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    int rl, nr;
    for (int it = 0; it < 25; it++) begin
      base = AW'($urandom);
      rl = $urandom_range(0, 5);
      nr = $urandom_range(0, 4);
      foreach (mem[i]) mem[i] = DW'($urandom);
      build_expected(int'(base), rl, nr);
      run_tile(base, rl, nr, 2, 400);
      n_tests++;
      if (!done_seen || got_q.size() != exp_q.size() || addr_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count got %0d words %0d reads done=%b exp %0d", it, got_q.size(), addr_q.size(), done_seen, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d got %h exp %h", it, i, got_q[i], exp_q[i]); end
      end
      for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if (addr_q[i] !== AW'(int'(base) + i)) begin
          n_fail++; $display("FAIL rand%0d_addr%0d got %h exp %h", it, i, addr_q[i], AW'(int'(base) + i));
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.row_len = '0; bus.num_rows = '0; bus.ready_buf = 1'b1;
    foreach (mem[i]) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_single_col();
    test_zero();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
